// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and the
// instruction store (slave).
interface cpu_sequencer_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [7:0]      imem_data;

   modport master (output imem_req, imem_addr, input imem_ack, imem_data);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / writeback with
// halt-and-resume on a run rising edge and a saturating retired counter.
module cpu_sequencer #(
   parameter int PC_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   cpu_sequencer_if.master        imem,
   output logic [7:0]             ir,
   input  logic                   dec_reg_write,
   input  logic                   dec_jump,
   input  logic                   dec_halt,
   output logic                   alu_en,
   output logic                   rf_we,
   output logic                   halted,
   output logic [2:0]             state,
   output logic [15:0]            retired
);

   if (PC_W < 5 || PC_W > 16) begin : g_bad_pc_w
      $error("cpu_sequencer: PC_W must be within 5..16");
   end

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   state_t          st_q, st_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic [15:0]     retired_q, retired_d;
   logic            run_q;
   logic            run_rise;
   logic            retire;
   logic            imem_req;

   // run_q follows run in every state, so a level held across HALT entry is no edge
   assign run_rise = run & ~run_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
         run_q     <= 1'b0;
      end else begin
         st_q      <= st_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
         run_q     <= run;
      end
   end

   always_comb begin
      st_d     = st_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      retire   = 1'b0;
      imem_req = 1'b0;
      alu_en   = 1'b0;
      rf_we    = 1'b0;
      halted   = 1'b0;
      case (st_q)
         S_IDLE: begin
            if (run_rise) st_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem.imem_ack) begin
               ir_d = imem.imem_data;
               st_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_halt) begin
               pc_d   = pc_q + PC_W'(1);
               retire = 1'b1;
               st_d   = S_HALT;
            end else if (dec_jump) begin
               st_d = S_WRITEBACK;
            end else begin
               st_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            alu_en = 1'b1;
            st_d   = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            // jumps never write the register file, even if the decoder says so
            rf_we  = dec_reg_write & ~dec_jump;
            pc_d   = dec_jump ? PC_W'(ir_q[4:0]) : pc_q + PC_W'(1);
            retire = 1'b1;
            st_d   = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (run_rise) st_d = S_FETCH;
         end
         default: st_d = S_IDLE;
      endcase
   end

   assign retired_d = (retire && retired_q != 16'hFFFF) ? retired_q + 16'd1 : retired_q;

   assign imem.imem_req  = imem_req;
   assign imem.imem_addr = pc_q;
   assign ir             = ir_q;
   assign state          = st_q;
   assign retired        = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the bench plays instruction memory and
// decoder, and an instruction-level model predicts every output each cycle.
module tb_cpu_sequencer;

   localparam int PC_W = 8;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [7:0]  ir;
   logic        dec_reg_write, dec_jump, dec_halt;
   logic        alu_en, rf_we, halted;
   logic [2:0]  state;
   logic [15:0] retired;

   cpu_sequencer_if #(.PC_W(PC_W)) imem_if ();

   cpu_sequencer #(.PC_W(PC_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .imem          (imem_if),
      .ir            (ir),
      .dec_reg_write (dec_reg_write),
      .dec_jump      (dec_jump),
      .dec_halt      (dec_halt),
      .alu_en        (alu_en),
      .rf_we         (rf_we),
      .halted        (halted),
      .state         (state),
      .retired       (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction memory with controllable ack latency
   logic [7:0] mem [256];
   logic       ack_en;
   int         stall_target;
   int         stall_cnt;
   logic       force_jump;

   assign imem_if.imem_ack  = imem_if.imem_req & ack_en & (stall_cnt >= stall_target);
   assign imem_if.imem_data = mem[imem_if.imem_addr];

   always @(posedge clk) begin
      if (imem_if.imem_req && ack_en && !imem_if.imem_ack) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
   end

   // toy decoder: 111xxxxx halt, 10xxxxxx jump, bit 5 requests a register write
   assign dec_halt      = (ir[7:5] == 3'b111);
   assign dec_jump      = (ir[7:6] == 2'b10) | force_jump;
   assign dec_reg_write = ir[5];

   int n_chk;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int          preload_seq;
   logic [15:0] preload_val;

   // ---------------- instruction-level model and per-cycle compare ----------
   typedef enum int {M_IDLE, M_FETCH, M_INSTR, M_HALT} mmode_t;
   typedef enum int {K_NORMAL, K_JUMP, K_HALT} kind_t;

   initial begin : model
      mmode_t     m_mode;
      kind_t      m_kind;
      int         m_k, m_len, m_seen;
      logic [7:0] m_pc, m_ir;
      logic [15:0] m_ret;
      logic       m_prev, m_regw, rise;
      logic [2:0] e_state;
      logic       e_alu, e_rf;
      m_mode = M_IDLE; m_kind = K_NORMAL; m_k = 0; m_len = 0; m_seen = 0;
      m_pc = '0; m_ir = '0; m_ret = '0; m_prev = 1'b0; m_regw = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_state", state, 0);
            chk("rst_req", imem_if.imem_req, 0);
            chk("rst_addr", imem_if.imem_addr, 0);
            chk("rst_ir", ir, 0);
            chk("rst_alu_rf_halt", {alu_en, rf_we, halted}, 0);
            chk("rst_retired", retired, 0);
            m_mode = M_IDLE; m_pc = '0; m_ir = '0; m_ret = '0; m_prev = 1'b0;
         end else begin
            if (preload_seq != m_seen) begin
               m_seen = preload_seq;
               m_ret  = preload_val;
            end
            e_alu = 1'b0; e_rf = 1'b0;
            case (m_mode)
               M_IDLE:  e_state = 3'd0;
               M_FETCH: e_state = 3'd1;
               M_HALT:  e_state = 3'd5;
               default: begin
                  if (m_k == 1) e_state = 3'd2;
                  else if (m_kind == K_JUMP) e_state = 3'd4;
                  else if (m_k == 2) e_state = 3'd3;
                  else e_state = 3'd4;
                  e_alu = (m_kind == K_NORMAL) && (m_k == 2);
                  e_rf  = (m_kind == K_NORMAL) && (m_k == 3) && m_regw;
               end
            endcase
            chk("state", state, e_state);
            chk("imem_req", imem_if.imem_req, (m_mode == M_FETCH));
            chk("imem_addr", imem_if.imem_addr, m_pc);
            chk("ir", ir, m_ir);
            chk("alu_en", alu_en, e_alu);
            chk("rf_we", rf_we, e_rf);
            chk("halted", halted, (m_mode == M_HALT));
            chk("retired", retired, m_ret);
            // predict the effect of the coming rising edge
            rise   = run & ~m_prev;
            m_prev = run;
            case (m_mode)
               M_IDLE, M_HALT: if (rise) m_mode = M_FETCH;
               M_FETCH: if (imem_if.imem_ack) begin
                  m_ir   = mem[m_pc];
                  m_regw = m_ir[5];
                  if (m_ir[7:5] == 3'b111) begin m_kind = K_HALT; m_len = 2; end
                  else if (m_ir[7:6] == 2'b10 || force_jump) begin m_kind = K_JUMP; m_len = 3; end
                  else begin m_kind = K_NORMAL; m_len = 4; end
                  m_k = 1;
                  m_mode = M_INSTR;
               end
               default: begin
                  if (m_k == m_len - 1) begin
                     if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
                     if (m_kind == K_JUMP) m_pc = {3'b000, m_ir[4:0]};
                     else m_pc = m_pc + 8'd1;
                     m_mode = (m_kind == K_HALT) ? M_HALT : M_FETCH;
                  end else begin
                     m_k++;
                  end
               end
            endcase
         end
      end
   end

   // ---------------- stimulus ------------------------------------------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // let the parked FETCH complete after `stall` wait cycles, then park again
   task automatic do_instr(input int stall, input string name);
      int i;
      stall_target = stall;
      ack_en = 1'b1;
      #1;
      i = 0;
      while (!imem_if.imem_ack && i < 64) begin
         tick(1);
         i++;
      end
      chk({name, "_ack_seen"}, imem_if.imem_ack, 1);
      tick(1);
      ack_en = 1'b0;
      i = 0;
      while (state != 3'd1 && state != 3'd5 && i < 8) begin
         tick(1);
         i++;
      end
      chk({name, "_done"}, (state == 3'd1 || state == 3'd5), 1);
   endtask

   task automatic wait_fetch_at(input logic [7:0] addr, input int budget, input string name);
      int i;
      i = 0;
      while (!(state == 3'd1 && imem_if.imem_addr == addr) && i < budget) begin
         tick(1);
         i++;
      end
      chk(name, {state, imem_if.imem_addr}, {3'd1, addr});
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      preload_seq = 0; preload_val = '0;
      for (int a = 0; a < 256; a++) mem[a] = 8'h01;
      ack_en = 1'b0; stall_target = 0; force_jump = 1'b0;
      run = 1'b0; rst_n = 1'b0;

      #1;
      chk("lit_reset_state", state, 0);
      chk("lit_reset_req", imem_if.imem_req, 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("lit_idle_after_reset", state, 0);

      // basic ADD at PC 0
      mem[0] = 8'h21;
      run = 1'b1; tick(1); run = 1'b0;
      do_instr(0, "add");
      chk("lit_add_pc", imem_if.imem_addr, 8'h01);
      chk("lit_add_retired", retired, 16'd1);

      // fetch stall of 5 cycles, with a run edge that must be ignored
      run = 1'b1;
      do_instr(5, "stall");
      run = 1'b0;
      do_instr(0, "nop2");
      chk("lit_pc3", imem_if.imem_addr, 8'h03);

      // jump at PC 3 -> 0x1A
      mem[3] = 8'h9A;
      force_jump = 1'b1;
      do_instr(0, "jump");
      force_jump = 1'b0;
      chk("lit_jump_pc", imem_if.imem_addr, 8'h1A);

      // jump whose decoder also requests a write -> rf_we stays low, PC 7
      mem[8'h1A] = 8'hA7;
      do_instr(0, "jump_rw");
      chk("lit_jump_rw_pc", imem_if.imem_addr, 8'h07);

      // halt at PC 7, halt outranks a forced jump, run held high throughout
      mem[7] = 8'hE0;
      run = 1'b1;
      force_jump = 1'b1;
      do_instr(0, "halt");
      force_jump = 1'b0;
      tick(3);
      chk("lit_halted", halted, 1);
      chk("lit_halt_pc", imem_if.imem_addr, 8'h08);
      chk("lit_halt_retired", retired, 16'd6);
      run = 1'b0; tick(1);
      run = 1'b1; tick(1);
      chk("lit_resume_fetch", {state, imem_if.imem_addr}, {3'd1, 8'h08});
      run = 1'b0;

      // jump to 0x1F, then run straight through 0xFF and wrap to 0
      mem[8] = 8'hBF;
      ack_en = 1'b1; stall_target = 0;
      wait_fetch_at(8'hFF, 2000, "reach_pc_ff");
      wait_fetch_at(8'h00, 16, "lit_wrap_pc0");
      ack_en = 1'b0;

      // saturation of retired from 0xFFFE
      force dut.retired_q = 16'hFFFE;
      preload_val = 16'hFFFE;
      preload_seq++;
      tick(1);
      release dut.retired_q;
      tick(1);
      do_instr(0, "sat1");
      chk("lit_sat1", retired, 16'hFFFF);
      do_instr(0, "sat2");
      chk("lit_sat2", retired, 16'hFFFF);

      // reset in mid-FETCH with an ack pending
      stall_target = 3; ack_en = 1'b1;
      tick(1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_mid_reset_req", imem_if.imem_req, 0);
      chk("lit_mid_reset_state", state, 0);
      chk("lit_mid_reset_retired", retired, 0);
      ack_en = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      chk("lit_idle_held", state, 0);

      // recovery: run rise and one ADD from address 0
      run = 1'b1; tick(1); run = 1'b0;
      do_instr(0, "recover");
      chk("lit_recover_pc", imem_if.imem_addr, 8'h01);
      chk("lit_recover_retired", retired, 16'd1);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
